// File: rtl/pipeline_trace_buffer_if.sv
// pipeline_trace_buffer_if
//   Bundles the processor-side probe signals, trace control, readout port
//   and status/statistics outputs of the pipeline trace buffer.
//   master : the processor / debug host (drives probes, control, readout requests)
//   slave  : the trace buffer itself
//   Probes   : pc_if, instr_if, wb_valid, wb_regwrite, wb_rd, wb_data, stall,
//              branch_taken, halt
//   Control  : arm, sw_trig
//   Readout  : rd_en, rd_idx -> rd_valid, rd_data (one cycle later)
//   Status   : state, done, trig_cause, entries, cycle_cnt, stall_cnt, retire_cnt
interface pipeline_trace_buffer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int REG_AW = 3,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = 32
);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int ENTRY_W = ADDR_W + 2 * DATA_W + REG_AW + 4;

  logic               arm;
  logic               sw_trig;
  logic [ADDR_W-1:0]  pc_if;
  logic [DATA_W-1:0]  instr_if;
  logic               wb_valid;
  logic               wb_regwrite;
  logic [REG_AW-1:0]  wb_rd;
  logic [DATA_W-1:0]  wb_data;
  logic               stall;
  logic               branch_taken;
  logic               halt;
  logic               rd_en;
  logic [IDX_W-1:0]   rd_idx;
  logic               rd_valid;
  logic [ENTRY_W-1:0] rd_data;
  logic [1:0]         state;
  logic               done;
  logic [1:0]         trig_cause;
  logic [IDX_W:0]     entries;
  logic [CNT_W-1:0]   cycle_cnt;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   retire_cnt;

  modport master (
    output arm, sw_trig, pc_if, instr_if, wb_valid, wb_regwrite, wb_rd,
           wb_data, stall, branch_taken, halt, rd_en, rd_idx,
    input  rd_valid, rd_data, state, done, trig_cause, entries,
           cycle_cnt, stall_cnt, retire_cnt
  );

  modport slave (
    input  arm, sw_trig, pc_if, instr_if, wb_valid, wb_regwrite, wb_rd,
           wb_data, stall, branch_taken, halt, rd_en, rd_idx,
    output rd_valid, rd_data, state, done, trig_cause, entries,
           cycle_cnt, stall_cnt, retire_cnt
  );
endinterface

// File: rtl/pipeline_trace_buffer.sv
// pipeline_trace_buffer
//   On-chip trace unit for the pipelined processor. While armed it records one
//   entry per cycle of fetch/writeback state into a circular buffer, freezes a
//   programmable number of entries after a halt, watchdog timeout or software
//   trigger, keeps cycle/stall/retire statistics, and reads the captured
//   history back oldest-first with one cycle of latency.
//   Ports:
//     clk   : clock
//     reset : synchronous, active-high reset
//     bus   : pipeline_trace_buffer_if.slave (probes, control, readout, status)
module pipeline_trace_buffer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int REG_AW    = 3,
  parameter int DEPTH     = 32,
  parameter int POST_TRIG = 8,
  parameter int TIMEOUT   = 200,
  parameter int CNT_W     = 32
) (
  input logic                    clk,
  input logic                    reset,
  pipeline_trace_buffer_if.slave bus
);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int ENT_W   = IDX_W + 1;
  localparam int PST_W   = IDX_W + 1;
  localparam int ENTRY_W = ADDR_W + 2 * DATA_W + REG_AW + 4;
  localparam int WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   wrPtr_q, wrPtr_d;
  logic               wrapped_q, wrapped_d;
  logic [ENT_W-1:0]   entries_q, entries_d;
  logic [CNT_W-1:0]   cycleCnt_q, cycleCnt_d;
  logic [CNT_W-1:0]   stallCnt_q, stallCnt_d;
  logic [CNT_W-1:0]   retireCnt_q, retireCnt_d;
  logic [WD_W-1:0]    watchdog_q, watchdog_d;
  logic [PST_W-1:0]   postCnt_q, postCnt_d;
  logic [1:0]         trigCause_q, trigCause_d;
  logic               rdValid_q;
  logic [ENTRY_W-1:0] rdData_q;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic               writeEn;
  logic               timeoutHit;
  logic               trigger;
  logic [ENTRY_W-1:0] wrEntry;
  logic [IDX_W-1:0]   rdPhys;

  assign wrEntry = {bus.pc_if, bus.instr_if, bus.wb_data, bus.wb_rd,
                    bus.wb_regwrite, bus.wb_valid, bus.stall, bus.branch_taken};

  // Once the buffer has wrapped, the oldest entry sits at the write pointer;
  // DEPTH is a power of two so the index sum wraps by truncation.
  assign rdPhys = wrapped_q ? (wrPtr_q + bus.rd_idx) : bus.rd_idx;

  // Next-state and capture bookkeeping.
  always_comb begin
    state_d     = state_q;
    wrPtr_d     = wrPtr_q;
    wrapped_d   = wrapped_q;
    entries_d   = entries_q;
    cycleCnt_d  = cycleCnt_q;
    stallCnt_d  = stallCnt_q;
    retireCnt_d = retireCnt_q;
    watchdog_d  = watchdog_q;
    postCnt_d   = postCnt_q;
    trigCause_d = trigCause_q;
    writeEn     = 1'b0;
    timeoutHit  = 1'b0;
    trigger     = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.arm) begin
          state_d     = ARMED;
          wrPtr_d     = '0;
          wrapped_d   = 1'b0;
          entries_d   = '0;
          cycleCnt_d  = '0;
          stallCnt_d  = '0;
          retireCnt_d = '0;
          watchdog_d  = '0;
          postCnt_d   = '0;
          trigCause_d = 2'd0;
        end
      end
      ARMED, POST: begin
        writeEn = 1'b1;
        wrPtr_d = wrPtr_q + IDX_W'(1);
        if (wrPtr_q == IDX_W'(DEPTH - 1)) wrapped_d = 1'b1;
        if (entries_q != ENT_W'(DEPTH)) entries_d = entries_q + ENT_W'(1);
        if (cycleCnt_q != '1) cycleCnt_d = cycleCnt_q + CNT_W'(1);
        if (bus.stall && (stallCnt_q != '1)) stallCnt_d = stallCnt_q + CNT_W'(1);
        if (bus.wb_valid && (retireCnt_q != '1)) retireCnt_d = retireCnt_q + CNT_W'(1);

        if (state_q == ARMED) begin
          // The cycle that would bring the idle run up to TIMEOUT is itself the trigger cycle.
          if (TIMEOUT != 0) begin
            timeoutHit = !bus.wb_valid && (32'(watchdog_q) == 32'(TIMEOUT - 1));
            watchdog_d = bus.wb_valid ? '0 : watchdog_q + WD_W'(1);
          end
          trigger = bus.halt || timeoutHit || bus.sw_trig;
          if (trigger) begin
            if (bus.halt)      trigCause_d = 2'd1;
            else if (timeoutHit) trigCause_d = 2'd2;
            else               trigCause_d = 2'd3;
            if (POST_TRIG == 0) begin
              state_d = DONE;
            end else begin
              state_d   = POST;
              postCnt_d = PST_W'(POST_TRIG);
            end
          end
        end else begin
          postCnt_d = postCnt_q - PST_W'(1);
          if (postCnt_q == PST_W'(1)) state_d = DONE;
        end
      end
    endcase
  end

  // State, statistics and readout registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wrPtr_q     <= '0;
      wrapped_q   <= 1'b0;
      entries_q   <= '0;
      cycleCnt_q  <= '0;
      stallCnt_q  <= '0;
      retireCnt_q <= '0;
      watchdog_q  <= '0;
      postCnt_q   <= '0;
      trigCause_q <= 2'd0;
      rdValid_q   <= 1'b0;
      rdData_q    <= '0;
    end else begin
      state_q     <= state_d;
      wrPtr_q     <= wrPtr_d;
      wrapped_q   <= wrapped_d;
      entries_q   <= entries_d;
      cycleCnt_q  <= cycleCnt_d;
      stallCnt_q  <= stallCnt_d;
      retireCnt_q <= retireCnt_d;
      watchdog_q  <= watchdog_d;
      postCnt_q   <= postCnt_d;
      trigCause_q <= trigCause_d;
      rdValid_q   <= bus.rd_en;
      if (bus.rd_en) rdData_q <= mem[rdPhys];
    end
  end

  // Trace RAM; not reset. A same-cycle read of the slot being written sees the old data.
  always_ff @(posedge clk) begin
    if (writeEn && !reset) mem[wrPtr_q] <= wrEntry;
  end

  assign bus.rd_valid   = rdValid_q;
  assign bus.rd_data    = rdData_q;
  assign bus.state      = state_q;
  assign bus.done       = (state_q == DONE);
  assign bus.trig_cause = trigCause_q;
  assign bus.entries    = entries_q;
  assign bus.cycle_cnt  = cycleCnt_q;
  assign bus.stall_cnt  = stallCnt_q;
  assign bus.retire_cnt = retireCnt_q;
endmodule
